// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice built from two half adders,
// fed by a carry flip-flop, processing one bit per clock LSB first.
module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [1:0]       ha0_d;
    logic [1:0]       ha1_d;
    logic             bit_d;
    logic             carry_d;

    // Returns {carry, sum} of a single-bit half adder.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full-adder slice on the current LSBs and the stored carry.
    always_comb begin
        ha0_d   = half_add(sa_q[0], sb_q[0]);
        ha1_d   = half_add(ha0_d[0], carry_q);
        bit_d   = ha1_d[0];
        carry_d = ha0_d[1] | ha1_d[1];
    end

    // Control FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            sa_q    <= {WIDTH{1'b0}};
            sb_q    <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= {CNT_W{1'b0}};
                        sum_q   <= {WIDTH{1'b0}};
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q   <= {bit_d, sum_q[WIDTH-1:1]};
                    sa_q    <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q    <= {1'b0, sb_q[WIDTH-1:1]};
                    carry_q <= carry_d;
                    // Counter parks at its last value so it never exceeds WIDTH-1.
                    if (cnt_q == CNT_LAST) begin
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
